// File: rtl/pkt_rx_intf.sv
// -----------------------------------------------------------------------------
// pkt_rx_intf
//
// Receive-side client for the 10G Ethernet MAC packet-RX FIFO port, running in
// the 156.25 MHz core clock domain. Whenever the MAC reports a complete packet
// and the block is enabled, it raises pkt_rx_ren and pulls exactly one packet.
// It then inserts a one-cycle gap before it considers the next packet.
//
// Every returned word is framing-checked against SOP/EOP. Accepted words are
// re-timed onto the out_* stream, exactly one cycle behind the inputs.
// Saturating statistics are kept for packets, bytes, errored packets and
// framing violations.
//
// Ports
//   clk_156m25          in   core clock, all flops on the rising edge
//   reset_156m25_n      in   synchronous active-low reset
//   enable              in   permits starting a new packet read (IDLE only)
//   clear_counters      in   synchronous clear of all statistics
//   pkt_rx_avail        in   MAC FIFO holds at least one complete packet
//   pkt_rx_data[63:0]   in   returned word, byte 0 in bits [63:56]
//   pkt_rx_val          in   data and flags valid this cycle
//   pkt_rx_sop/eop/err  in   start / end of packet, packet error (with EOP)
//   pkt_rx_mod[2:0]     in   valid bytes in the EOP word, 0 means 8
//   pkt_rx_ren          out  registered read request to the MAC
//   out_data[63:0]      out  re-timed data word
//   out_val/sop/eop/err out  re-timed qualifiers
//   out_mod[2:0]        out  re-timed mod
//   busy                out  registered, high whenever the FSM is not IDLE
//   rx_pkt_count        out  completed packets (32-bit, saturating)
//   rx_byte_count       out  bytes in completed packets (32-bit, saturating)
//   rx_err_count        out  completed packets flagged with err (16-bit)
//   rx_frame_err_count  out  SOP/EOP framing violations (16-bit)
// -----------------------------------------------------------------------------
module pkt_rx_intf (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic        enable,
    input  logic        clear_counters,
    input  logic        pkt_rx_avail,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_val,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic        pkt_rx_err,
    input  logic [2:0]  pkt_rx_mod,
    output logic        pkt_rx_ren,
    output logic [63:0] out_data,
    output logic        out_val,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_err,
    output logic [2:0]  out_mod,
    output logic        busy,
    output logic [31:0] rx_pkt_count,
    output logic [31:0] rx_byte_count,
    output logic [15:0] rx_err_count,
    output logic [15:0] rx_frame_err_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        ren_next;

    logic        in_pkt;
    logic [15:0] pkt_len;

    logic        word_stray;
    logic        word_restart;
    logic        word_accept;
    logic        pkt_done;
    logic [15:0] word_bytes;
    logic [15:0] len_base;
    logic [16:0] len_sum;
    logic [15:0] len_final;
    logic [32:0] byte_sum;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // Read-request FSM. The request is asserted in the same cycle the FSM
    // leaves IDLE and is held through READ. It is dropped on the edge that
    // samples the EOP word, even if the framing checker rejects that word,
    // because the MAC has finished the packet either way. GAP then forces
    // one cycle with the request low before IDLE re-evaluates avail.
    always_comb begin
        state_next = state;
        ren_next   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && pkt_rx_avail) begin
                    state_next = READ;
                    ren_next   = 1'b1;
                end
            end
            READ: begin
                if (pkt_rx_val && pkt_rx_eop) begin
                    state_next = GAP;
                end else begin
                    ren_next = 1'b1;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, read request and busy are all registered together.
    // busy therefore always matches (state != IDLE) with no decode glitch.
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state      <= IDLE;
            pkt_rx_ren <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            pkt_rx_ren <= ren_next;
            busy       <= (state_next != IDLE);
        end
    end

    // Framing classification of the incoming word. The check runs in every
    // FSM state so that a stray word arriving in IDLE or GAP is still seen.
    // A repeated SOP abandons the open packet but is itself a good start.
    // The accumulator then simply restarts from zero on that word.
    assign word_stray   = pkt_rx_val && !pkt_rx_sop && !in_pkt;
    assign word_restart = pkt_rx_val &&  pkt_rx_sop &&  in_pkt;
    assign word_accept  = pkt_rx_val && (pkt_rx_sop || in_pkt);
    assign pkt_done     = word_accept && pkt_rx_eop;

    // Length of the packet including the current word. Non-EOP words always
    // carry 8 bytes; the EOP word carries mod bytes, where 0 encodes a full 8.
    assign word_bytes = (pkt_rx_eop && (pkt_rx_mod != 3'd0)) ? {13'd0, pkt_rx_mod} : 16'd8;
    assign len_base   = pkt_rx_sop ? 16'd0 : pkt_len;
    assign len_sum    = {1'b0, len_base} + {1'b0, word_bytes};
    assign len_final  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign byte_sum   = {1'b0, rx_byte_count} + {17'd0, len_final};

    // Packet tracking. The accumulator is cleared once the packet closes.
    // A dropped stray word leaves both in_pkt and the length untouched.
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            in_pkt  <= 1'b0;
            pkt_len <= 16'd0;
        end else if (word_accept) begin
            in_pkt  <= !pkt_rx_eop;
            pkt_len <= pkt_rx_eop ? 16'd0 : len_final;
        end
    end

    // Re-timed output stream. Only accepted words produce out_val. The
    // qualifiers are forced low on other cycles so a stale EOP/SOP can never
    // be read alongside a low out_val. Data and mod simply hold.
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            out_data <= 64'd0;
            out_val  <= 1'b0;
            out_sop  <= 1'b0;
            out_eop  <= 1'b0;
            out_err  <= 1'b0;
            out_mod  <= 3'd0;
        end else begin
            out_val <= word_accept;
            out_sop <= word_accept && pkt_rx_sop;
            out_eop <= word_accept && pkt_rx_eop;
            out_err <= word_accept && pkt_rx_err;
            if (word_accept) begin
                out_data <= pkt_rx_data;
                out_mod  <= pkt_rx_mod;
            end
        end
    end

    // Statistics. These are updated on the EOP edge, so the new values appear
    // together with out_eop. A clear wins over any increment in the same
    // cycle, and every counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n || clear_counters) begin
            rx_pkt_count       <= 32'd0;
            rx_byte_count      <= 32'd0;
            rx_err_count       <= 16'd0;
            rx_frame_err_count <= 16'd0;
        end else begin
            if (pkt_done) begin
                rx_pkt_count  <= sat_inc32(rx_pkt_count);
                rx_byte_count <= byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
                if (pkt_rx_err) begin
                    rx_err_count <= sat_inc16(rx_err_count);
                end
            end
            if (word_stray || word_restart) begin
                rx_frame_err_count <= sat_inc16(rx_frame_err_count);
            end
        end
    end

endmodule

// File: tb/tb_pkt_rx_intf.sv
// -----------------------------------------------------------------------------
// tb_pkt_rx_intf
//
// Testbench for pkt_rx_intf. The bench plays the MAC side: it raises avail,
// waits for the read request, and then returns a packet one word per cycle.
//
// The reference model works at packet level. It counts the words of the open
// packet and derives the length from the word count and the final mod. Every
// forwarded word is queued with the cycle it must appear on. For EOP words the
// statistics expected on that same cycle are queued as well. A separate
// monitor pops the queue whenever out_val is seen.
// -----------------------------------------------------------------------------
module tb_pkt_rx_intf;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        clear_counters;
    logic        pkt_rx_avail;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic        pkt_rx_err;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_ren;
    logic [63:0] out_data;
    logic        out_val;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic [2:0]  out_mod;
    logic        busy;
    logic [31:0] rx_pkt_count;
    logic [31:0] rx_byte_count;
    logic [15:0] rx_err_count;
    logic [15:0] rx_frame_err_count;

    pkt_rx_intf dut (
        .clk_156m25         (clk),
        .reset_156m25_n     (reset_n),
        .enable             (enable),
        .clear_counters     (clear_counters),
        .pkt_rx_avail       (pkt_rx_avail),
        .pkt_rx_data        (pkt_rx_data),
        .pkt_rx_val         (pkt_rx_val),
        .pkt_rx_sop         (pkt_rx_sop),
        .pkt_rx_eop         (pkt_rx_eop),
        .pkt_rx_err         (pkt_rx_err),
        .pkt_rx_mod         (pkt_rx_mod),
        .pkt_rx_ren         (pkt_rx_ren),
        .out_data           (out_data),
        .out_val            (out_val),
        .out_sop            (out_sop),
        .out_eop            (out_eop),
        .out_err            (out_err),
        .out_mod            (out_mod),
        .busy               (busy),
        .rx_pkt_count       (rx_pkt_count),
        .rx_byte_count      (rx_byte_count),
        .rx_err_count       (rx_err_count),
        .rx_frame_err_count (rx_frame_err_count)
    );

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  mod;
        int          cyc;
        longint      pkts;
        longint      bytes;
        longint      errs;
    } exp_rec_t;

    exp_rec_t exp_q[$];
    exp_rec_t mon_rec;

    int     vectors;
    int     miscompares;
    int     cyc;

    // Packet-level reference state.
    bit     m_open;
    int     m_words;
    longint m_pkt;
    longint m_bytes;
    longint m_err;
    longint m_ferr;

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    function automatic longint sat_add(input longint v, input longint inc, input longint maxv);
        return (v + inc > maxv) ? maxv : v + inc;
    endfunction

    // Drive one valid word for one cycle and fold it into the reference model.
    task automatic applyStimulus(input logic [63:0] d, input logic s, input logic e,
                                 input logic er, input logic [2:0] m, input logic clr);
        exp_rec_t rec;
        bit       accepted;
        pkt_rx_data    = d;
        pkt_rx_val     = 1'b1;
        pkt_rx_sop     = s;
        pkt_rx_eop     = e;
        pkt_rx_err     = er;
        pkt_rx_mod     = m;
        clear_counters = clr;
        accepted = s || m_open;
        if (!accepted) begin
            m_ferr = sat_add(m_ferr, 1, 65535);
        end else begin
            if (s && m_open) m_ferr = sat_add(m_ferr, 1, 65535);
            if (s) m_words = 0;
            m_words = m_words + 1;
            m_open  = !e;
            if (e) begin
                m_pkt   = sat_add(m_pkt, 1, 64'hFFFF_FFFF);
                m_bytes = sat_add(m_bytes, (m_words - 1) * 8 + ((m == 3'd0) ? 8 : int'(m)), 64'hFFFF_FFFF);
                if (er) m_err = sat_add(m_err, 1, 65535);
            end
        end
        if (clr) begin
            m_pkt = 0; m_bytes = 0; m_err = 0; m_ferr = 0;
        end
        if (accepted) begin
            rec.data = d; rec.sop = s; rec.eop = e; rec.err = er; rec.mod = m;
            rec.cyc = cyc + 1;
            rec.pkts = m_pkt; rec.bytes = m_bytes; rec.errs = m_err;
            exp_q.push_back(rec);
        end
        @(posedge clk); #1;
        pkt_rx_val     = 1'b0;
        pkt_rx_sop     = 1'b0;
        pkt_rx_eop     = 1'b0;
        pkt_rx_err     = 1'b0;
        clear_counters = 1'b0;
    endtask

    task automatic pulseClear();
        clear_counters = 1'b1;
        m_pkt = 0; m_bytes = 0; m_err = 0; m_ferr = 0;
        @(posedge clk); #1;
        clear_counters = 1'b0;
    endtask

    // MAC-side packet handshake: offer the packet, wait for ren, return words.
    // abort_after > 0 stops after that many words (used for mid-packet reset).
    task automatic sendPacket(input int nwords, input logic [2:0] lastmod, input logic lasterr,
                              input logic clr_eop, input int abort_after);
        int t;
        bit last;
        pkt_rx_avail = 1'b1;
        t = 0;
        while (pkt_rx_ren !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t = t + 1;
        end
        checkOutput("ren_rise_latency", 64'(t), 64'd1);
        pkt_rx_avail = 1'b0;
        if (pkt_rx_ren !== 1'b1) return;
        @(posedge clk); #1;
        checkOutput("ren_held_before_data", pkt_rx_ren, 1'b1);
        for (int i = 0; i < nwords; i++) begin
            if (abort_after > 0 && i == abort_after) return;
            last = (i == nwords - 1);
            applyStimulus({$urandom, $urandom}, i == 0, last,
                          last ? lasterr : 1'($urandom),
                          last ? lastmod : 3'($urandom), last && clr_eop);
            if (last) checkOutput("ren_fall_after_eop", pkt_rx_ren, 1'b0);
            else      checkOutput("ren_held_in_read", pkt_rx_ren, 1'b1);
        end
        checkOutput("busy_in_gap", busy, 1'b1);
        @(posedge clk); #1;
        checkOutput("ren_low_after_gap", pkt_rx_ren, 1'b0);
        checkOutput("busy_back_idle", busy, 1'b0);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_pkt_count"},  rx_pkt_count,       64'(m_pkt));
        checkOutput({tag, "_byte_count"}, rx_byte_count,      64'(m_bytes));
        checkOutput({tag, "_err_count"},  rx_err_count,       64'(m_err));
        checkOutput({tag, "_frame_err"},  rx_frame_err_count, 64'(m_ferr));
    endtask

    task automatic modelReset();
        m_open = 0; m_words = 0; m_pkt = 0; m_bytes = 0; m_err = 0; m_ferr = 0;
    endtask

    // Scoreboard monitor: compares each out_val word against the queue head,
    // including the cycle it was due on; flags missing and unexpected words.
    always @(negedge clk) begin
        if (out_val === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("out_val_unexpected", out_val, 1'b0);
            end else begin
                mon_rec = exp_q.pop_front();
                checkOutput("out_latency_cycle", 64'(cyc), 64'(mon_rec.cyc));
                checkOutput("out_data", out_data, mon_rec.data);
                checkOutput("out_flags", {out_sop, out_eop, out_err, out_mod},
                            {mon_rec.sop, mon_rec.eop, mon_rec.err, mon_rec.mod});
                if (mon_rec.eop) begin
                    checkOutput("eop_pkt_count",  rx_pkt_count,  64'(mon_rec.pkts));
                    checkOutput("eop_byte_count", rx_byte_count, 64'(mon_rec.bytes));
                    checkOutput("eop_err_count",  rx_err_count,  64'(mon_rec.errs));
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            checkOutput("out_val_missing", out_val, 1'b1);
            mon_rec = exp_q.pop_front();
        end
    end

    initial begin
        int kind;
        int n;
        vectors = 0; miscompares = 0; cyc = 0;
        modelReset();
        reset_n = 1'b0; enable = 1'b0; clear_counters = 1'b0; pkt_rx_avail = 1'b0;
        pkt_rx_data = 64'd0; pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0;
        pkt_rx_err = 1'b0; pkt_rx_mod = 3'd0;

        // Reset with random inputs for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            enable = 1'($urandom); pkt_rx_avail = 1'($urandom); clear_counters = 1'($urandom);
            pkt_rx_data = {$urandom, $urandom}; pkt_rx_val = 1'($urandom);
            pkt_rx_sop = 1'($urandom); pkt_rx_eop = 1'($urandom);
            pkt_rx_err = 1'($urandom); pkt_rx_mod = 3'($urandom);
        end
        checkOutput("reset_ren", pkt_rx_ren, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_out_val", out_val, 1'b0);
        checkOutput("reset_out_data", out_data, 64'd0);
        checkOutput("reset_out_flags", {out_sop, out_eop, out_err, out_mod}, 6'd0);
        enable = 1'b0; pkt_rx_avail = 1'b0; clear_counters = 1'b0; pkt_rx_val = 1'b0;
        pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0; pkt_rx_err = 1'b0; pkt_rx_mod = 3'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checkCounters("reset");
        @(posedge clk); #1;
        enable = 1'b1;

        $display("[TB] full-word packet");
        sendPacket(8, 3'd0, 1'b0, 1'b0, 0);
        checkOutput("full_pkt_count", rx_pkt_count, 64'd1);
        checkOutput("full_byte_count", rx_byte_count, 64'd64);

        $display("[TB] partial last word plus error");
        pulseClear();
        sendPacket(8, 3'd5, 1'b0, 1'b0, 0);
        sendPacket(1, 3'd3, 1'b1, 1'b0, 0);
        checkOutput("partial_byte_count", rx_byte_count, 64'd64);
        checkOutput("partial_pkt_count", rx_pkt_count, 64'd2);
        checkOutput("partial_err_count", rx_err_count, 64'd1);

        $display("[TB] framing");
        pulseClear();
        applyStimulus({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("stray_word_dropped", out_val, 1'b0);
        applyStimulus({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus({$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("framing_frame_err", rx_frame_err_count, 64'd2);
        checkOutput("framing_pkt_count", rx_pkt_count, 64'd1);
        checkOutput("framing_byte_count", rx_byte_count, 64'd24);

        $display("[TB] control");
        enable = 1'b0; pkt_rx_avail = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("ren_disabled", pkt_rx_ren, 1'b0);
        end
        pkt_rx_avail = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        sendPacket(4, 3'd2, 1'b1, 1'b1, 0);
        checkOutput("clear_pkt_count", rx_pkt_count, 64'd0);
        checkOutput("clear_byte_count", rx_byte_count, 64'd0);
        checkOutput("clear_err_count", rx_err_count, 64'd0);
        checkOutput("clear_frame_err", rx_frame_err_count, 64'd0);

        $display("[TB] reset mid-packet");
        sendPacket(8, 3'd0, 1'b0, 1'b0, 3);
        reset_n = 1'b0;
        modelReset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_q.delete();
        reset_n = 1'b1;
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_ren", pkt_rx_ren, 1'b0);
        checkCounters("midreset");
        @(posedge clk); #1;
        sendPacket(8, 3'd0, 1'b0, 1'b0, 0);
        checkOutput("after_reset_pkt_count", rx_pkt_count, 64'd1);
        checkOutput("after_reset_byte_count", rx_byte_count, 64'd64);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 120; it++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                applyStimulus({$urandom, $urandom}, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 1'b0);
            end else if (kind == 1) begin
                n = $urandom_range(0, 3);
                applyStimulus({$urandom, $urandom}, 1'b1, 1'b0, 1'($urandom), 3'($urandom), 1'b0);
                applyStimulus({$urandom, $urandom}, 1'b1, 1'b0, 1'($urandom), 3'($urandom), 1'b0);
                for (int k = 0; k < n; k++)
                    applyStimulus({$urandom, $urandom}, 1'b0, 1'b0, 1'($urandom), 3'($urandom), 1'b0);
                applyStimulus({$urandom, $urandom}, 1'b0, 1'b1, 1'($urandom), 3'($urandom), 1'b0);
            end else if (kind == 2) begin
                pulseClear();
            end else begin
                sendPacket($urandom_range(1, 10), 3'($urandom), 1'($urandom),
                           ($urandom_range(0, 9) == 0), 0);
            end
            checkCounters("random");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
